// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared types and constants for the instruction loader
package rv32i_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR_ADDR,
        ST_HDR_CNT,
        ST_CHECK,
        ST_DATA,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } loader_state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'b00,
        ERR_ALIGN   = 2'b01,
        ERR_RANGE   = 2'b10,
        ERR_TIMEOUT = 2'b11
    } loader_err_e;

    localparam int LOADER_HDR_BYTES = 4;

endpackage

// File: rtl/rv32i_byte_packer.sv
// rv32i_byte_packer: gathers four stream bytes into a little-endian 32-bit word
module rv32i_byte_packer
    import rv32i_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    output logic [31:0] word,
    output logic        word_valid
);

    logic [1:0]  idx;
    logic [23:0] buffer;

    // the last byte is forwarded combinationally so the word is usable on the edge that consumes it
    assign word       = {byte_data, buffer};
    assign word_valid = byte_valid && idx == 2'(LOADER_HDR_BYTES - 1);

    // lane index and the three lower byte lanes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx    <= '0;
            buffer <= '0;
        end else if (clear) begin
            idx    <= '0;
            buffer <= '0;
        end else if (byte_valid) begin
            idx <= idx + 2'd1;
            if (!word_valid)
                buffer[8*idx +: 8] <= byte_data;
        end
    end

endmodule

// File: rtl/rv32i_instruction_loader.sv
// rv32i_instruction_loader: parses an image header from a byte stream and writes instruction words with a full handshake
module rv32i_instruction_loader
    import rv32i_pkg::*;
#(
    parameter int MEM_BYTES  = 4096,
    parameter int WR_TIMEOUT = 64,
    parameter int TIMEOUT_W  = 7
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_load_start,
    input  logic        i_byte_valid,
    input  logic [7:0]  i_byte,
    output logic        o_byte_ready,
    output logic        o_instruction_wr_en,
    output logic [31:0] o_instruction_wr_addr,
    output logic [31:0] o_instruction_wr_data,
    input  logic        i_instruction_wr_valid,
    output logic        o_core_hold,
    output logic        o_load_done,
    output logic        o_load_error,
    output logic [1:0]  o_error_code
);

    loader_state_e        state, state_next;
    loader_err_e          err_code, check_err;
    logic [31:0]          addr, cnt, data, word;
    logic [TIMEOUT_W-1:0] tmo;
    logic [34:0]          end_addr;
    logic                 word_valid, byte_take, start_ok, timed_out, write_ack;

    assign start_ok  = i_load_start && (state == ST_IDLE || state == ST_DONE || state == ST_ERROR);
    assign byte_take = i_byte_valid && o_byte_ready;
    assign write_ack = state == ST_WRITE && i_instruction_wr_valid;
    assign timed_out = tmo == TIMEOUT_W'(WR_TIMEOUT - 1);
    // wide enough that base + 4*count can never wrap back into the legal range
    assign end_addr  = {3'b000, addr} + {1'b0, cnt, 2'b00};
    assign check_err = addr[1:0] != 2'b00 ? ERR_ALIGN :
                       end_addr > 35'(MEM_BYTES) ? ERR_RANGE : ERR_NONE;

    assign o_instruction_wr_addr = addr;
    assign o_instruction_wr_data = data;
    assign o_error_code          = err_code;

    rv32i_byte_packer u_packer (
        .clk        (i_clk),
        .rst_n      (i_rst_n),
        .clear      (start_ok),
        .byte_valid (byte_take),
        .byte_data  (i_byte),
        .word       (word),
        .word_valid (word_valid)
    );

    // state register; reset drops the session immediately
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    // next-state decision
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE, ST_DONE, ST_ERROR: state_next = i_load_start ? ST_HDR_ADDR : state;
            ST_HDR_ADDR:                state_next = word_valid ? ST_HDR_CNT : state;
            ST_HDR_CNT:                 state_next = word_valid ? ST_CHECK : state;
            ST_CHECK:                   state_next = check_err != ERR_NONE ? ST_ERROR :
                                                     cnt == 32'd0 ? ST_DONE : ST_DATA;
            ST_DATA:                    state_next = word_valid ? ST_WRITE : state;
            ST_WRITE:                   state_next = i_instruction_wr_valid ? (cnt == 32'd1 ? ST_DONE : ST_DATA) :
                                                     timed_out ? ST_ERROR : state;
            default:                    state_next = ST_IDLE;
        endcase
    end

    // outputs decoded purely from state so reset clears them asynchronously
    always_comb begin
        o_byte_ready        = state == ST_HDR_ADDR || state == ST_HDR_CNT || state == ST_DATA;
        o_instruction_wr_en = state == ST_WRITE;
        o_core_hold         = state != ST_DONE;
        o_load_done         = state == ST_DONE;
        o_load_error        = state == ST_ERROR;
    end

    // header fields, current word, write pointer, remaining count, timeout and error code
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            addr     <= '0;
            cnt      <= '0;
            data     <= '0;
            tmo      <= '0;
            err_code <= ERR_NONE;
        end else begin
            tmo <= state == ST_WRITE ? tmo + 1'b1 : '0;
            if (start_ok)
                err_code <= ERR_NONE;
            if (state == ST_HDR_ADDR && word_valid)
                addr <= word;
            if (state == ST_HDR_CNT && word_valid)
                cnt <= word;
            if (state == ST_DATA && word_valid)
                data <= word;
            if (state == ST_CHECK)
                err_code <= check_err;
            if (write_ack) begin
                addr <= addr + 32'd4;
                cnt  <= cnt - 32'd1;
            end else if (state == ST_WRITE && timed_out) begin
                err_code <= ERR_TIMEOUT;
            end
        end
    end

endmodule

// File: tb/tb_rv32i_instruction_loader.sv
// tb_rv32i_instruction_loader: randomized sessions checked against a header-level reference model
module tb_rv32i_instruction_loader;

    localparam int MEM_BYTES  = 4096;
    localparam int WR_TIMEOUT = 64;
    localparam int TIMEOUT_W  = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_start = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        ack = 1'b0;
    logic        byte_ready, wr_en, core_hold, load_done, load_error;
    logic [31:0] wr_addr, wr_data;
    logic [1:0]  error_code;

    int vectors = 0;
    int miscompares = 0;

    int          ack_delay = 1;
    int          wr_cycles = 0;
    int          last_wr_len = 0;
    int          viol_after_ack = 0;
    int          viol_stable = 0;
    int          viol_ready = 0;
    int          run_len = 0;
    logic        prev_ack = 1'b0;
    logic        prev_en = 1'b0;
    logic [31:0] held_addr = 0;
    logic [31:0] held_data = 0;
    logic [63:0] writes[$];
    logic [31:0] rb, rc;

    always #5 clk = ~clk;

    rv32i_instruction_loader #(
        .MEM_BYTES  (MEM_BYTES),
        .WR_TIMEOUT (WR_TIMEOUT),
        .TIMEOUT_W  (TIMEOUT_W)
    ) dut (
        .i_clk                  (clk),
        .i_rst_n                (rst_n),
        .i_load_start           (load_start),
        .i_byte_valid           (byte_valid),
        .i_byte                 (byte_data),
        .o_byte_ready           (byte_ready),
        .o_instruction_wr_en    (wr_en),
        .o_instruction_wr_addr  (wr_addr),
        .o_instruction_wr_data  (wr_data),
        .i_instruction_wr_valid (ack),
        .o_core_hold            (core_hold),
        .o_load_done            (load_done),
        .o_load_error           (load_error),
        .o_error_code           (error_code)
    );

    task automatic check(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        vectors++;
        if (got_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got_v, exp_v);
        end
    endtask

    // fetch-stage responder: one ack pulse on wr_en cycle ack_delay, plus handshake watchdogs
    initial forever begin
        @(negedge clk);
        if (prev_ack && wr_en)
            viol_after_ack++;
        if (wr_en && prev_en && !prev_ack && (wr_addr !== held_addr || wr_data !== held_data))
            viol_stable++;
        if (wr_en && byte_ready)
            viol_ready++;
        if (!wr_en && prev_en)
            last_wr_len = run_len;
        run_len = wr_en ? run_len + 1 : 0;
        if (wr_en)
            wr_cycles++;
        ack = wr_en && run_len == ack_delay;
        if (ack)
            writes.push_back({wr_addr, wr_data});
        prev_ack  = ack;
        prev_en   = wr_en;
        held_addr = wr_addr;
        held_data = wr_data;
    end

    task automatic send_byte(input logic [7:0] b, input int maxgap, input bit noise);
        int guard = 0;
        repeat ($urandom_range(maxgap, 0)) begin
            load_start = noise && ($urandom_range(3, 0) == 0);
            @(negedge clk);
        end
        load_start = 1'b0;
        byte_valid = 1'b1;
        byte_data  = b;
        while (!byte_ready && guard < 300) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 300)
            check("byte_accept_timeout", 0, 1);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap, input bit noise);
        for (int k = 0; k < 4; k++)
            send_byte(w[8*k +: 8], maxgap, noise);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    task automatic run_session(input string tag, input logic [31:0] base, input logic [31:0] cnt,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input int maxgap, input int delay, input bit noise);
        logic [31:0] words[$];
        logic [63:0] exp_w[$];
        logic [63:0] end_b;
        logic [1:0]  exp_code;
        bit          exp_done;
        int          nsend, exp_cycles, guard, g0, c0;
        logic [31:0] w;
        g0 = writes.size();
        c0 = wr_cycles;
        ack_delay = delay;
        end_b = {32'b0, base} + {30'b0, cnt, 2'b00};
        if (base[1:0] != 2'b00) begin
            exp_code = 2'b01; nsend = 0;
        end else if (end_b > 64'(MEM_BYTES)) begin
            exp_code = 2'b10; nsend = 0;
        end else if (cnt == 0) begin
            exp_code = 2'b00; nsend = 0;
        end else if (delay > WR_TIMEOUT) begin
            exp_code = 2'b11; nsend = 1;
        end else begin
            exp_code = 2'b00; nsend = int'(cnt);
        end
        exp_done = exp_code == 2'b00;
        exp_cycles = exp_code == 2'b11 ? WR_TIMEOUT : exp_done ? nsend * delay : 0;
        for (int i = 0; i < nsend; i++) begin
            w = i == 0 ? w0 : i == 1 ? w1 : $urandom;
            words.push_back(w);
            if (exp_done)
                exp_w.push_back({base + 32'(4 * i), w});
        end
        pulse_start();
        send_word(base, maxgap, noise);
        send_word(cnt, maxgap, noise);
        foreach (words[i])
            send_word(words[i], maxgap, noise);
        guard = 0;
        while (!(load_done || load_error) && guard < 600) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 600)
            check({tag, "_end_timeout"}, 0, 1);
        @(negedge clk);
        check({tag, "_done"}, load_done, exp_done);
        check({tag, "_error"}, load_error, !exp_done);
        check({tag, "_code"}, error_code, exp_code);
        check({tag, "_hold"}, core_hold, !exp_done);
        check({tag, "_ready_idle"}, byte_ready, 0);
        check({tag, "_nwrites"}, writes.size() - g0, exp_w.size());
        for (int i = 0; i < exp_w.size() && g0 + i < writes.size(); i++)
            check({tag, "_write"}, writes[g0 + i], exp_w[i]);
        check({tag, "_wr_cycles"}, wr_cycles - c0, exp_cycles);
        if (exp_code == 2'b11)
            check({tag, "_timeout_len"}, last_wr_len, WR_TIMEOUT);
        check({tag, "_wr_after_ack"}, viol_after_ack, 0);
        check({tag, "_wr_stable"}, viol_stable, 0);
        check({tag, "_ready_in_write"}, viol_ready, 0);
    endtask

    initial begin
        int guard;
        #1;
        check("rst_hold", core_hold, 1);
        check("rst_wr_en", wr_en, 0);
        check("rst_ready", byte_ready, 0);
        check("rst_done", load_done, 0);
        check("rst_error", load_error, 0);
        check("rst_code", error_code, 0);
        check("rst_addr", wr_addr, 0);
        check("rst_data", wr_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_session("normal", 32'h10, 32'd2, 32'h00000013, 32'h00A00093, 0, 1, 0);
        run_session("misalign", 32'h6, 32'd1, 32'h1, 32'h2, 0, 1, 0);
        run_session("range_edge", 32'hFF8, 32'd2, $urandom, $urandom, 0, 2, 0);
        run_session("range_over", 32'hFF8, 32'd3, $urandom, $urandom, 0, 1, 0);
        run_session("range_huge", 32'h0, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        run_session("range_wrap", 32'h4, 32'hFFFFFFFF, 0, 0, 0, 1, 0);
        run_session("range_full", 32'h0, 32'd1024, $urandom, $urandom, 0, 1, 0);
        run_session("range_full1", 32'h0, 32'd1025, 0, 0, 0, 1, 0);
        run_session("timeout", 32'h100, 32'd1, $urandom, 0, 0, 1000, 0);
        run_session("ack_at_limit", 32'h100, 32'd2, $urandom, $urandom, 0, WR_TIMEOUT, 0);
        run_session("gaps", 32'h10, 32'd2, 32'h00000013, 32'h00A00093, 5, 1, 1);
        run_session("slow_ack", 32'h10, 32'd2, 32'h00000013, 32'h00A00093, 2, 10, 0);

        ack_delay = 1000;
        pulse_start();
        send_word(32'h20, 0, 0);
        send_word(32'd1, 0, 0);
        send_word($urandom, 0, 0);
        guard = 0;
        while (!wr_en && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("mid_reset_reach_write", wr_en, 1);
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("mid_reset_wr_en", wr_en, 0);
        check("mid_reset_hold", core_hold, 1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_ready", byte_ready, 0);
        check("post_reset_done", load_done, 0);
        check("post_reset_error", load_error, 0);
        check("post_reset_addr", wr_addr, 0);
        check("post_reset_data", wr_data, 0);
        run_session("after_reset_cnt0", 32'h0, 32'd0, 0, 0, 0, 1, 0);

        for (int s = 0; s < 20; s++) begin
            rb = 32'($urandom_range(MEM_BYTES / 4, 0)) * 32'd4;
            if ($urandom_range(7, 0) == 0)
                rb = rb | 32'($urandom_range(3, 1));
            rc = 32'($urandom_range(6, 0));
            if ($urandom_range(9, 0) == 0)
                rc = $urandom;
            run_session("rand", rb, rc, $urandom, $urandom, 3,
                        $urandom_range(9, 0) == 0 ? WR_TIMEOUT + 6 : int'($urandom_range(12, 1)), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
